pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 97 +++++++++
 tb/tb_pc_fetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Fetch stage with IF/ID register: PC sequencing, delay-slot redirects and
// a pending-target state for redirects that arrive while memory is waiting.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  PCSrc_D,
  input  logic [15:0] Imm16_D,
  input  logic [25:0] Instr26_D,
  input  logic [31:0] RsData_D,
  input  logic        Stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_F,
  output logic [31:0] Instr_D,
  output logic [31:0] PC4_D,
  output logic        Valid_D
);

  typedef enum logic {RUN, PEND} state_t;

  state_t      state, state_nxt;
  logic [31:0] tgt, tgt_nxt;
  logic [31:0] pc_nxt, instr_nxt, pc4_nxt;
  logic        valid_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic        redir;

  assign imem_req  = !Stall;
  assign imem_addr = PC_F;
  assign pc_plus4  = PC_F + 32'd4;
  assign redir     = Valid_D && !Stall && (PCSrc_D != 2'b00);

  always_comb begin
    target = pc_plus4;
    case (PCSrc_D)
      2'b01:   target = PC4_D + {{14{Imm16_D[15]}}, Imm16_D, 2'b00};
      2'b10:   target = {PC4_D[31:28], Instr26_D, 2'b00};
      2'b11:   target = RsData_D;
      default: target = pc_plus4;
    endcase
  end

  // The instruction in flight when redir occurs is the delay slot; the
  // target only replaces the PC after that fetch is accepted.
  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    pc_nxt    = PC_F;
    instr_nxt = Instr_D;
    pc4_nxt   = PC4_D;
    valid_nxt = Valid_D;
    if (!Stall) begin
      if (imem_ready) begin
        instr_nxt = imem_rdata;
        pc4_nxt   = pc_plus4;
        valid_nxt = 1'b1;
        state_nxt = RUN;
        if (state == PEND)
          pc_nxt = tgt;
        else if (redir)
          pc_nxt = target;
        else
          pc_nxt = pc_plus4;
      end else begin
        valid_nxt = 1'b0;
        if (state == RUN && redir) begin
          tgt_nxt   = target;
          state_nxt = PEND;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      tgt     <= 32'd0;
      PC_F    <= RESET_PC;
      Instr_D <= 32'd0;
      PC4_D   <= 32'd0;
      Valid_D <= 1'b0;
    end else begin
      state   <= state_nxt;
      tgt     <= tgt_nxt;
      PC_F    <= pc_nxt;
      Instr_D <= instr_nxt;
      PC4_D   <= pc4_nxt;
      Valid_D <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: vector table through a scoreboard
// queue, plus hand-written reset and async-reset-in-PEND sequences.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  PCSrc_D;
  logic [15:0] Imm16_D;
  logic [25:0] Instr26_D;
  logic [31:0] RsData_D;
  logic        Stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC_F;
  logic [31:0] Instr_D;
  logic [31:0] PC4_D;
  logic        Valid_D;

  int n_compared;
  int n_mismatched;

  typedef struct {
    logic        stall;
    logic        ready;
    logic [1:0]  pcsrc;
    logic [15:0] imm;
    logic [25:0] i26;
    logic [31:0] rs;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic [31:0] exp_pc4;
    logic [31:0] exp_instr;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs[NVEC];
  vec_t sb[$];
  logic [31:0] cur_pc;

  pc_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk       (clk),
    .reset     (reset),
    .PCSrc_D   (PCSrc_D),
    .Imm16_D   (Imm16_D),
    .Instr26_D (Instr26_D),
    .RsData_D  (RsData_D),
    .Stall     (Stall),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .PC_F      (PC_F),
    .Instr_D   (Instr_D),
    .PC4_D     (PC4_D),
    .Valid_D   (Valid_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compare(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drives one vector at the falling edge, checks the combinational fetch
  // request, queues the post-edge expectation and lets the edge happen.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    Stall      = v.stall;
    imem_ready = v.ready;
    PCSrc_D    = v.pcsrc;
    Imm16_D    = v.imm;
    Instr26_D  = v.i26;
    RsData_D   = v.rs;
    imem_rdata = v.rdata;
    #1;
    compare($sformatf("v%0d imem_req", idx), {31'd0, imem_req}, {31'd0, v.exp_req});
    compare($sformatf("v%0d imem_addr", idx), imem_addr, cur_pc);
    sb.push_back(v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    if (sb.size() == 0) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL v%0d scoreboard: got empty expected entry", idx);
      return;
    end
    e = sb.pop_front();
    compare($sformatf("v%0d PC_F", idx), PC_F, e.exp_pc);
    compare($sformatf("v%0d Valid_D", idx), {31'd0, Valid_D}, {31'd0, e.exp_valid});
    compare($sformatf("v%0d PC4_D", idx), PC4_D, e.exp_pc4);
    compare($sformatf("v%0d Instr_D", idx), Instr_D, e.exp_instr);
    cur_pc = e.exp_pc;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    cur_pc       = 32'h0000_3000;

    //             stall ready src imm       i26          rs            rdata         req pc            v  pc4           instr
    vecs[0]  = '{1'b0, 1'b1, 2'b00, 16'h0, 26'h0,       32'h0,        32'h1000_0000, 1'b1, 32'h0000_3004, 1'b1, 32'h0000_3004, 32'h1000_0000};
    vecs[1]  = '{1'b0, 1'b1, 2'b00, 16'h0, 26'h0,       32'h0,        32'h1000_0001, 1'b1, 32'h0000_3008, 1'b1, 32'h0000_3008, 32'h1000_0001};
    vecs[2]  = '{1'b0, 1'b1, 2'b01, 16'hFFFE, 26'h0,    32'h0,        32'h1000_0002, 1'b1, 32'h0000_3000, 1'b1, 32'h0000_300C, 32'h1000_0002};
    vecs[3]  = '{1'b0, 1'b1, 2'b00, 16'h0, 26'h0,       32'h0,        32'h1000_0003, 1'b1, 32'h0000_3004, 1'b1, 32'h0000_3004, 32'h1000_0003};
    vecs[4]  = '{1'b0, 1'b0, 2'b11, 16'h0, 26'h0,       32'h0000_3400, 32'hDEAD_0004, 1'b1, 32'h0000_3004, 1'b0, 32'h0000_3004, 32'h1000_0003};
    vecs[5]  = '{1'b0, 1'b0, 2'b11, 16'h0, 26'h0,       32'h0000_5555, 32'hDEAD_0005, 1'b1, 32'h0000_3004, 1'b0, 32'h0000_3004, 32'h1000_0003};
    vecs[6]  = '{1'b0, 1'b1, 2'b11, 16'h0, 26'h0,       32'h0000_5555, 32'h1000_0006, 1'b1, 32'h0000_3400, 1'b1, 32'h0000_3008, 32'h1000_0006};
    vecs[7]  = '{1'b0, 1'b1, 2'b00, 16'h0, 26'h0,       32'h0,        32'h1000_0007, 1'b1, 32'h0000_3404, 1'b1, 32'h0000_3404, 32'h1000_0007};
    vecs[8]  = '{1'b1, 1'b1, 2'b10, 16'h0, 26'h0000E00, 32'h0,        32'hDEAD_0008, 1'b0, 32'h0000_3404, 1'b1, 32'h0000_3404, 32'h1000_0007};
    vecs[9]  = '{1'b1, 1'b1, 2'b10, 16'h0, 26'h0000E00, 32'h0,        32'hDEAD_0009, 1'b0, 32'h0000_3404, 1'b1, 32'h0000_3404, 32'h1000_0007};
    vecs[10] = '{1'b1, 1'b0, 2'b10, 16'h0, 26'h0000E00, 32'h0,        32'hDEAD_000A, 1'b0, 32'h0000_3404, 1'b1, 32'h0000_3404, 32'h1000_0007};
    vecs[11] = '{1'b0, 1'b1, 2'b10, 16'h0, 26'h0000E00, 32'h0,        32'h1000_000B, 1'b1, 32'h0000_3800, 1'b1, 32'h0000_3408, 32'h1000_000B};
    vecs[12] = '{1'b0, 1'b1, 2'b00, 16'h0, 26'h0,       32'h0,        32'h1000_000C, 1'b1, 32'h0000_3804, 1'b1, 32'h0000_3804, 32'h1000_000C};
    vecs[13] = '{1'b0, 1'b0, 2'b00, 16'h0, 26'h0,       32'h0,        32'hDEAD_000D, 1'b1, 32'h0000_3804, 1'b0, 32'h0000_3804, 32'h1000_000C};
    vecs[14] = '{1'b0, 1'b1, 2'b01, 16'h0010, 26'h0,    32'h0,        32'h1000_000E, 1'b1, 32'h0000_3808, 1'b1, 32'h0000_3808, 32'h1000_000E};
    vecs[15] = '{1'b0, 1'b1, 2'b11, 16'h0, 26'h0,       32'hF000_0000, 32'h1000_000F, 1'b1, 32'hF000_0000, 1'b1, 32'h0000_380C, 32'h1000_000F};
    vecs[16] = '{1'b0, 1'b1, 2'b00, 16'h0, 26'h0,       32'h0,        32'h1000_0010, 1'b1, 32'hF000_0004, 1'b1, 32'hF000_0004, 32'h1000_0010};
    vecs[17] = '{1'b0, 1'b1, 2'b10, 16'h0, 26'h3FFFFFF, 32'h0,        32'h1000_0011, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'hF000_0008, 32'h1000_0011};
    vecs[18] = '{1'b0, 1'b1, 2'b00, 16'h0, 26'h0,       32'h0,        32'h1000_0012, 1'b1, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h1000_0012};

    reset      = 1'b1;
    Stall      = 1'b0;
    imem_ready = 1'b0;
    PCSrc_D    = 2'b00;
    Imm16_D    = 16'h0;
    Instr26_D  = 26'h0;
    RsData_D   = 32'h0;
    imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    compare("reset PC_F", PC_F, 32'h0000_3000);
    compare("reset Valid_D", {31'd0, Valid_D}, 32'd0);
    compare("reset PC4_D", PC4_D, 32'd0);
    compare("reset Instr_D", Instr_D, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i], i);
      checkOutput(i);
    end

    // Enter PEND with a jr while memory waits, then reset between edges.
    @(negedge clk);
    Stall      = 1'b0;
    imem_ready = 1'b0;
    PCSrc_D    = 2'b11;
    RsData_D   = 32'h0000_5000;
    @(posedge clk);
    #1;
    compare("pend Valid_D", {31'd0, Valid_D}, 32'd0);
    compare("pend PC_F", PC_F, 32'h0000_0000);
    #2;
    reset = 1'b1;
    #1;
    compare("async PC_F", PC_F, 32'h0000_3000);
    compare("async Valid_D", {31'd0, Valid_D}, 32'd0);
    compare("async PC4_D", PC4_D, 32'd0);
    compare("async Instr_D", Instr_D, 32'd0);
    @(negedge clk);
    reset      = 1'b0;
    PCSrc_D    = 2'b00;
    imem_ready = 1'b1;
    imem_rdata = 32'h2000_0000;
    #1;
    compare("post-reset imem_req", {31'd0, imem_req}, 32'd1);
    compare("post-reset imem_addr", imem_addr, 32'h0000_3000);
    @(posedge clk);
    #1;
    compare("post-reset PC_F (state RUN)", PC_F, 32'h0000_3004);
    compare("post-reset Valid_D", {31'd0, Valid_D}, 32'd1);
    compare("post-reset Instr_D", Instr_D, 32'h2000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
